// File: rtl/decode_stage.sv
// RV64I decode stage: field extraction, immediate generation, integer register file,
// register scoreboard with fetch back-pressure, and the execute pipeline latch.
module decode_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] DE_NPC,
    input  logic [XLEN-1:0] DE_PC,
    input  logic [31:0]     DE_IR,
    input  logic            DE_V,
    input  logic            WB_V,
    input  logic            WB_LD_REG,
    input  logic [4:0]      WB_DR,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            V_DEP_STALL,
    output logic            V_DE_FE_BR_STALL,
    output logic            EXE_V,
    output logic [XLEN-1:0] EXE_PC,
    output logic [XLEN-1:0] EXE_NPC,
    output logic [31:0]     EXE_IR,
    output logic [XLEN-1:0] EXE_SR1,
    output logic [XLEN-1:0] EXE_SR2,
    output logic [XLEN-1:0] EXE_IMM,
    output logic [4:0]      EXE_DR,
    output logic            EXE_LD_REG
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = DE_IR[6:0];
    assign rd     = DE_IR[11:7];
    assign rs1    = DE_IR[19:15];
    assign rs2    = DE_IR[24:20];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
    assign imm_s = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]};
    assign imm_b = {{(XLEN-13){DE_IR[31]}}, DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){DE_IR[31]}}, DE_IR[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){DE_IR[31]}}, DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0};

    logic [XLEN-1:0] imm;
    logic            use_rs1;
    logic            use_rs2;
    logic            ld_reg;
    logic            is_cf;

    // Unknown opcodes fall through to the defaults and travel down as NOPs.
    always_comb begin
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        ld_reg  = 1'b0;
        is_cf   = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP32: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ld_reg  = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD: begin
                imm     = imm_i;
                use_rs1 = 1'b1;
                ld_reg  = 1'b1;
            end
            OPC_JALR: begin
                imm     = imm_i;
                use_rs1 = 1'b1;
                ld_reg  = 1'b1;
                is_cf   = 1'b1;
            end
            OPC_STORE: begin
                imm     = imm_s;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm     = imm_b;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                is_cf   = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm    = imm_u;
                ld_reg = 1'b1;
            end
            OPC_JAL: begin
                imm    = imm_j;
                ld_reg = 1'b1;
                is_cf  = 1'b1;
            end
            default: begin
            end
        endcase
        if (rd == 5'd0) begin
            ld_reg = 1'b0;
        end
    end

    logic [XLEN-1:0] regs [NREG];
    logic            wb_we;
    logic [XLEN-1:0] sr1;
    logic [XLEN-1:0] sr2;

    assign wb_we = WB_V && WB_LD_REG && (WB_DR != 5'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[WB_DR] <= WB_DATA;
        end
    end

    // Write-through bypass lets a consumer issue in the same cycle its producer retires.
    always_comb begin
        sr1 = regs[rs1];
        if (rs1 == 5'd0) begin
            sr1 = '0;
        end else if (wb_we && (WB_DR == rs1)) begin
            sr1 = WB_DATA;
        end
        sr2 = regs[rs2];
        if (rs2 == 5'd0) begin
            sr2 = '0;
        end else if (wb_we && (WB_DR == rs2)) begin
            sr2 = WB_DATA;
        end
    end

    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_clear;
    logic [NREG-1:0] eff_busy;
    logic [NREG-1:0] rd_set;
    logic [NREG-1:0] busy_next;
    logic            dep_stall;
    logic            issue;

    always_comb begin
        wb_clear = '0;
        if (WB_V && WB_LD_REG) begin
            wb_clear[WB_DR] = 1'b1;
        end
    end

    assign eff_busy  = busy & ~wb_clear;
    assign dep_stall = DE_V && ((use_rs1 && eff_busy[rs1]) ||
                                (use_rs2 && eff_busy[rs2]) ||
                                (ld_reg  && eff_busy[rd]));
    assign issue     = DE_V && !dep_stall;

    // Applying the set after the clear makes a same-cycle set win over a writeback clear.
    always_comb begin
        rd_set = '0;
        if (issue && ld_reg) begin
            rd_set[rd] = 1'b1;
        end
        busy_next    = eff_busy | rd_set;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign V_DEP_STALL      = dep_stall;
    assign V_DE_FE_BR_STALL = DE_V && is_cf;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            EXE_V      <= 1'b0;
            EXE_PC     <= '0;
            EXE_NPC    <= '0;
            EXE_IR     <= '0;
            EXE_SR1    <= '0;
            EXE_SR2    <= '0;
            EXE_IMM    <= '0;
            EXE_DR     <= '0;
            EXE_LD_REG <= 1'b0;
        end else begin
            EXE_V      <= issue;
            EXE_PC     <= DE_PC;
            EXE_NPC    <= DE_NPC;
            EXE_IR     <= DE_IR;
            EXE_SR1    <= sr1;
            EXE_SR2    <= sr2;
            EXE_IMM    <= imm;
            EXE_DR     <= rd;
            EXE_LD_REG <= ld_reg;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes expected execute-latch contents into a
// scoreboard queue, and a negedge monitor pops and compares them one cycle later.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [63:0] DE_NPC;
    logic [63:0] DE_PC;
    logic [31:0] DE_IR;
    logic        DE_V;
    logic        WB_V;
    logic        WB_LD_REG;
    logic [4:0]  WB_DR;
    logic [63:0] WB_DATA;
    logic        V_DEP_STALL;
    logic        V_DE_FE_BR_STALL;
    logic        EXE_V;
    logic [63:0] EXE_PC;
    logic [63:0] EXE_NPC;
    logic [31:0] EXE_IR;
    logic [63:0] EXE_SR1;
    logic [63:0] EXE_SR2;
    logic [63:0] EXE_IMM;
    logic [4:0]  EXE_DR;
    logic        EXE_LD_REG;

    decode_stage #(.XLEN(64), .NREG(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .DE_NPC(DE_NPC), .DE_PC(DE_PC), .DE_IR(DE_IR), .DE_V(DE_V),
        .WB_V(WB_V), .WB_LD_REG(WB_LD_REG), .WB_DR(WB_DR), .WB_DATA(WB_DATA),
        .V_DEP_STALL(V_DEP_STALL), .V_DE_FE_BR_STALL(V_DE_FE_BR_STALL),
        .EXE_V(EXE_V), .EXE_PC(EXE_PC), .EXE_NPC(EXE_NPC), .EXE_IR(EXE_IR),
        .EXE_SR1(EXE_SR1), .EXE_SR2(EXE_SR2), .EXE_IMM(EXE_IMM),
        .EXE_DR(EXE_DR), .EXE_LD_REG(EXE_LD_REG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [31:0] ir;
        logic        wv;
        logic [4:0]  wdr;
        logic [63:0] wdata;
        logic        dep;
        logic        br;
        logic [63:0] imm;
        logic        chk_sr;
        logic [63:0] sr1;
        logic [63:0] sr2;
        logic        ld;
    } vec_t;

    typedef struct {
        int          due;
        logic        v;
        logic [63:0] pc;
        logic [31:0] ir;
        logic [63:0] imm;
        logic        chk_sr;
        logic [63:0] sr1;
        logic [63:0] sr2;
        logic [4:0]  dr;
        logic        ld;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [63:0] pc_ctr = 64'h1000;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic dv, input logic [31:0] ir,
                                input logic wv, input logic [4:0] wdr, input logic [63:0] wdata,
                                input logic dep, input logic br, input logic [63:0] imm,
                                input logic chk_sr, input logic [63:0] sr1, input logic [63:0] sr2,
                                input logic ld);
        vec_t v;
        v.rst = rst;  v.dv = dv;   v.ir = ir;
        v.wv = wv;    v.wdr = wdr; v.wdata = wdata;
        v.dep = dep;  v.br = br;   v.imm = imm;
        v.chk_sr = chk_sr; v.sr1 = sr1; v.sr2 = sr2; v.ld = ld;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET     = v.rst;
        DE_V      = v.dv;
        DE_IR     = v.ir;
        DE_PC     = pc_ctr;
        DE_NPC    = pc_ctr + 64'd4;
        WB_V      = v.wv;
        WB_LD_REG = v.wv;
        WB_DR     = v.wdr;
        WB_DATA   = v.wdata;
        e.due    = cyc + 1;
        e.v      = !v.rst && v.dv && !v.dep;
        e.pc     = pc_ctr;
        e.ir     = v.ir;
        e.imm    = v.imm;
        e.chk_sr = v.chk_sr;
        e.sr1    = v.sr1;
        e.sr2    = v.sr2;
        e.dr     = v.ir[11:7];
        e.ld     = v.ld;
        sb.push_back(e);
        pc_ctr = pc_ctr + 64'd4;
        @(negedge CLK);
        if (!v.rst) begin
            checkOutput("dep_stall", 64'(V_DEP_STALL), 64'(v.dep));
            checkOutput("br_stall", 64'(V_DE_FE_BR_STALL), 64'(v.br));
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checkOutput("exe_v", 64'(EXE_V), 64'(e.v));
            if (e.v) begin
                checkOutput("exe_pc", EXE_PC, e.pc);
                checkOutput("exe_npc", EXE_NPC, e.pc + 64'd4);
                checkOutput("exe_ir", 64'(EXE_IR), 64'(e.ir));
                checkOutput("exe_imm", EXE_IMM, e.imm);
                checkOutput("exe_dr", 64'(EXE_DR), 64'(e.dr));
                checkOutput("exe_ld_reg", 64'(EXE_LD_REG), 64'(e.ld));
                if (e.chk_sr) begin
                    checkOutput("exe_sr1", EXE_SR1, e.sr1);
                    checkOutput("exe_sr2", EXE_SR2, e.sr2);
                end
            end
        end else if (EXE_V === 1'b1) begin
            checkOutput("exe_v_unexpected", 64'(EXE_V), 64'd0);
        end
    end

    initial begin
        vec_t vecs[$];
        RESET = 1'b1; DE_V = 1'b0; DE_IR = '0; DE_PC = '0; DE_NPC = '0;
        WB_V = 1'b0; WB_LD_REG = 1'b0; WB_DR = '0; WB_DATA = '0;

        // Reset held two cycles while decode and writeback are both active.
        vecs.push_back(mk(1, 1, 32'h00500093, 1, 5'd5, 64'hDEAD, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0));
        vecs.push_back(mk(1, 1, 32'h00500093, 1, 5'd5, 64'hDEAD, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0));
        // addi x7,x5,0 reads x5, which reset must have left at zero.
        vecs.push_back(mk(0, 1, 32'h00028393, 0, 5'd0, 64'h0, 0, 0, 64'h0, 1, 64'h0, 64'h0, 1));
        // Independent stream: addi x1,x0,5 / addi x2,x0,7.
        vecs.push_back(mk(0, 1, 32'h00500093, 0, 5'd0, 64'h0, 0, 0, 64'h5, 1, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00700113, 0, 5'd0, 64'h0, 0, 0, 64'h7, 1, 64'h0, 64'h0, 1));
        // RAW: add x3,x1,x1 stalls until x1 writes back, then issues with the bypassed value.
        vecs.push_back(mk(0, 1, 32'h001081B3, 0, 5'd0, 64'h0, 1, 0, 64'h0, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h001081B3, 0, 5'd0, 64'h0, 1, 0, 64'h0, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h001081B3, 1, 5'd1, 64'h5, 0, 0, 64'h0, 1, 64'h5, 64'h5, 1));
        // addi x10,x1,0: x1 is free and now holds 5.
        vecs.push_back(mk(0, 1, 32'h00008513, 0, 5'd0, 64'h0, 0, 0, 64'h0, 1, 64'h5, 64'h0, 1));
        // add x11,x2,x0: x2 still busy from the stream above.
        vecs.push_back(mk(0, 1, 32'h000105B3, 0, 5'd0, 64'h0, 1, 0, 64'h0, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h000105B3, 1, 5'd2, 64'h123456789ABCDEF0, 0, 0, 64'h0, 1, 64'h123456789ABCDEF0, 64'h0, 1));
        // beq x0,x0,-8.
        vecs.push_back(mk(0, 1, 32'hFE000CE3, 0, 5'd0, 64'h0, 0, 1, 64'hFFFFFFFFFFFFFFF8, 1, 64'h0, 64'h0, 0));
        // beq x3,x0,-8: branch stall persists through a dependency stall.
        vecs.push_back(mk(0, 1, 32'hFE018CE3, 0, 5'd0, 64'h0, 1, 1, 64'h0, 0, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, 1, 32'hFE018CE3, 1, 5'd3, 64'hA, 0, 1, 64'hFFFFFFFFFFFFFFF8, 1, 64'hA, 64'h0, 0));
        // addi x0,x0,1 then add x4,x0,x0 while a writeback targets x0.
        vecs.push_back(mk(0, 1, 32'h00100013, 0, 5'd0, 64'h0, 0, 0, 64'h1, 1, 64'h0, 64'h5, 0));
        vecs.push_back(mk(0, 1, 32'h00000233, 1, 5'd0, 64'hBAD, 0, 0, 64'h0, 1, 64'h0, 64'h0, 1));
        // lui x6 twice; the second issues while writeback clears x6, so x6 stays busy.
        vecs.push_back(mk(0, 1, 32'h12345337, 0, 5'd0, 64'h0, 0, 0, 64'h12345000, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h12345337, 1, 5'd6, 64'h77, 0, 0, 64'h12345000, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00030613, 0, 5'd0, 64'h0, 1, 0, 64'h0, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00030613, 1, 5'd6, 64'h99, 0, 0, 64'h0, 1, 64'h99, 64'h0, 1));
        // jal x0,16 / sd x0,-4(x0) / auipc x8,0xFFFFF / jalr x9,-1(x0).
        vecs.push_back(mk(0, 1, 32'h0100006F, 0, 5'd0, 64'h0, 0, 1, 64'h10, 0, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, 1, 32'hFE003E23, 0, 5'd0, 64'h0, 0, 0, 64'hFFFFFFFFFFFFFFFC, 1, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFFF417, 0, 5'd0, 64'h0, 0, 0, 64'hFFFFFFFFFFFFF000, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'hFFF004E7, 0, 5'd0, 64'h0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0, 64'h0, 1));
        // WAW: addi x9,x0,1 waits for the jalr's x9 writeback.
        vecs.push_back(mk(0, 1, 32'h00100493, 0, 5'd0, 64'h0, 1, 0, 64'h0, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00100493, 1, 5'd9, 64'h55, 0, 0, 64'h1, 1, 64'h0, 64'h5, 1));
        // DE_V=0 suppresses both stalls even with a busy source or a branch.
        vecs.push_back(mk(0, 0, 32'h007386B3, 0, 5'd0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, 0, 32'hFE000CE3, 0, 5'd0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, 1, 32'h007386B3, 0, 5'd0, 64'h0, 1, 0, 64'h0, 0, 64'h0, 64'h0, 1));
        vecs.push_back(mk(0, 0, 32'h00000000, 0, 5'd0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0));
        vecs.push_back(mk(0, 0, 32'h00000000, 0, 5'd0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            if (i == 1) begin
                checkOutput("reset_exe_v", 64'(EXE_V), 64'd0);
                checkOutput("reset_exe_ld_reg", 64'(EXE_LD_REG), 64'd0);
                checkOutput("reset_exe_dr", 64'(EXE_DR), 64'd0);
                checkOutput("reset_exe_imm", EXE_IMM, 64'd0);
                checkOutput("reset_exe_sr1", EXE_SR1, 64'd0);
                checkOutput("reset_exe_pc", EXE_PC, 64'd0);
            end
        end

        repeat (2) @(negedge CLK);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
